// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache between fetch and the memory arbiter.
// Latency: hit 0 cycles (combinational); miss 2+N cycles, where N = cycles iwait stays high.
// Backpressure: ihit stays low while filling; iwait stalls the fill; dropping imemREN abandons it.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inval,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t            state_q;
    logic              valid_q [SETS];
    logic [TAGW-1:0]   tag_q   [SETS];
    logic [31:0]       data_q  [SETS];

    logic [IDX-1:0]    idx;
    logic [TAGW-1:0]   tag;
    logic              hit;
    logic              unused_byte_bits;

    assign idx = imemaddr[IDX+1:2];
    assign tag = imemaddr[31:IDX+2];
    assign unused_byte_bits = ^imemaddr[1:0];

    assign hit      = (state_q == IDLE) && imemREN && valid_q[idx] && (tag_q[idx] == tag);
    assign ihit     = hit;
    assign imemload = hit ? data_q[idx] : 32'h0;
    assign iREN     = (state_q == FETCH) && imemREN;
    assign iaddr    = (state_q == FETCH) ? {imemaddr[31:2], 2'b00} : 32'h0;

    // The fill always uses the address present on the completing cycle, so a
    // redirect mid-fetch lands the new word under the new tag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (inval) begin
            state_q <= IDLE;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (!imemREN) begin
                        state_q <= IDLE;
                    end else if (!iwait) begin
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= tag;
                        data_q[idx]  <= iload;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hand-written corner sequences and
// random traffic checked against a line-address cache model.
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        inval;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    icache #(.SETS(SETS)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inval(inval), .iREN(iREN),
        .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each frame remembers which word address it holds.
    logic [29:0] m_line [int];
    logic [31:0] m_data [int];
    bit          m_fetch = 1'b0;

    logic        o_hit, o_iren;
    logic [31:0] o_load, o_iaddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    // One clock cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(input logic ren, input logic [31:0] addr, input logic inv,
                        input logic wt, input logic [31:0] ld);
        int          ix;
        logic        e_hit, e_iren;
        logic [31:0] e_load, e_iaddr;
        imemREN = ren; imemaddr = addr; inval = inv; iwait = wt; iload = ld;
        #2;
        ix      = frame_of(addr);
        e_hit   = !m_fetch && ren && m_line.exists(ix) && (m_line[ix] == addr[31:2]);
        e_load  = e_hit ? m_data[ix] : 32'h0;
        e_iren  = m_fetch && ren;
        e_iaddr = m_fetch ? {addr[31:2], 2'b00} : 32'h0;
        o_hit = ihit; o_load = imemload; o_iren = iREN; o_iaddr = iaddr;
        chk("model_ihit", {31'b0, o_hit}, {31'b0, e_hit});
        chk("model_imemload", o_load, e_load);
        chk("model_iREN", {31'b0, o_iren}, {31'b0, e_iren});
        chk("model_iaddr", o_iaddr, e_iaddr);
        @(posedge CLK);
        if (inv) begin
            m_line.delete(); m_data.delete(); m_fetch = 1'b0;
        end else if (!m_fetch) begin
            m_fetch = ren && !e_hit;
        end else if (!ren) begin
            m_fetch = 1'b0;
        end else if (!wt) begin
            m_line[ix] = addr[31:2]; m_data[ix] = ld; m_fetch = 1'b0;
        end
        @(negedge CLK);
    endtask

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        inv;
        logic        wt;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[2]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h1111_2222, 1'b0, 32'h0,         1'b1, 32'h80};
        vecs[7]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b1, 32'h1111_2222, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h2001_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[10] = '{1'b1, 32'h43, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h80};
        vecs[14] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2001_0005, 1'b0, 32'h0};

        nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; inval = 1'b0; iwait = 1'b1; iload = 32'h0;
        #12;
        chk("reset_ihit", {31'b0, ihit}, 32'h0);
        chk("reset_imemload", imemload, 32'h0);
        chk("reset_iREN", {31'b0, iREN}, 32'h0);
        chk("reset_iaddr", iaddr, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        // Miss with N=2, conflict eviction, unaligned hit, withdrawn fetch.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].ren, vecs[i].addr, vecs[i].inv, vecs[i].wt, vecs[i].ld);
            chk($sformatf("vec%0d_ihit", i), {31'b0, o_hit}, {31'b0, vecs[i].e_hit});
            chk($sformatf("vec%0d_imemload", i), o_load, vecs[i].e_load);
            chk($sformatf("vec%0d_iREN", i), {31'b0, o_iren}, {31'b0, vecs[i].e_iren});
            chk($sformatf("vec%0d_iaddr", i), o_iaddr, vecs[i].e_iaddr);
        end

        // Redirect mid-fetch: the fill lands under the address of the completing cycle.
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        chk("redirect_iaddr", o_iaddr, 32'h200);
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'hDEAD_BEEF);
        step(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        chk("redirect_hit", {31'b0, o_hit}, 32'h1);
        chk("redirect_data", o_load, 32'hDEAD_BEEF);
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        chk("redirect_old_miss", {31'b0, o_hit}, 32'h0);

        // Withdraw the request while iwait is high: no fill, back to IDLE.
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
        step(1'b0, 32'h100, 1'b0, 1'b1, 32'h1234_5678);
        chk("withdraw_iREN", {31'b0, o_iren}, 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        chk("withdraw_keeps_frame", o_load, 32'hDEAD_BEEF);

        // inval on the same edge as a fill drops the fill and all prior lines.
        step(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h10, 1'b0, 1'b0, 32'hAAAA_0010);
        step(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
        chk("inval_pre_hit", o_load, 32'hAAAA_0010);
        step(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h20, 1'b1, 1'b0, 32'hBBBB_0020);
        step(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
        chk("inval_0x10_miss", {31'b0, o_hit}, 32'h0);
        step(1'b0, 32'h10, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
        chk("inval_0x20_miss", {31'b0, o_hit}, 32'h0);
        step(1'b0, 32'h20, 1'b0, 1'b1, 32'h0);

        // Random traffic over a small address pool so hits, conflicts and redirects all occur.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
            step(($urandom_range(0, 99) < 88), a, ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 1) == 1), $urandom);
        end

        // Asynchronous reset in the middle of a fetch.
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0BAD_F00D);
        step(1'b1, 32'h300, 1'b0, 1'b1, 32'h0);
        imemREN = 1'b1; imemaddr = 32'h300; iwait = 1'b1; inval = 1'b0;
        #2;
        chk("prereset_iREN", {31'b0, iREN}, 32'h1);
        nRST = 1'b0;
        #1;
        chk("midreset_iREN", {31'b0, iREN}, 32'h0);
        chk("midreset_ihit", {31'b0, ihit}, 32'h0);
        chk("midreset_iaddr", iaddr, 32'h0);
        m_line.delete(); m_data.delete(); m_fetch = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        chk("postreset_0x40_miss", {31'b0, o_hit}, 32'h0);
        step(1'b0, 32'h40, 1'b0, 1'b1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, single-word-block instruction cache sitting between the pipeline's fetch port (imemREN/imemaddr/ihit/imemload) and the memory arbiter's instruction port. It is the block directly downstream of the datapath's instruction fetch path. Hits return the instruction in the same cycle. Misses run a two-state fill FSM that holds `ihit` low until memory delivers the word.

## Interface
Parameters:
- SETS, 16, number of frames; power of two, ≥2. IDX = log2(SETS).

Ports:
- CLK  in  1  clock; all state updates on rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath instruction read request
- imemaddr  in  32  datapath fetch address (PC)
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  instruction word to fetch latch
- inval  in  1  synchronous invalidate-all strobe
- iREN  out  1  read request to memory arbiter
- iaddr  out  32  word-aligned address to memory arbiter
- iwait  in  1  memory busy; low = iload valid this cycle
- iload  in  32  word returned from memory

## Operation
- Address split: [1:0] ignored; index = imemaddr[IDX+1:2]; tag = imemaddr[31:IDX+2] (30−IDX bits).
- Per frame: valid (1), tag, data (32). Reset clears all valid, tag, and data to 0.
- Hit condition: state==IDLE && imemREN && valid[index] && tag[index]==tag.
- Outputs:
  - ihit = hit condition.
  - imemload = data[index] when ihit, else 32'h0.
  - iREN = (state==FETCH) && imemREN.
  - iaddr = {imemaddr[31:2],2'b00} when state==FETCH, else 32'h0.
- FSM states IDLE, FETCH:
  - IDLE → FETCH: imemREN && !hit && !inval.
  - FETCH, imemREN==0: → IDLE, no fill (request withdrawn, e.g. halt).
  - FETCH, imemREN && !iwait: write frame[index] = {1, tag, iload}; → IDLE.
  - FETCH, imemREN && iwait: stay.
- Address change during FETCH (redirect/flush): the fill uses the address present on the completing cycle. The arbiter restarts its latency on an iaddr change, so the filled tag/data are always consistent.
- inval: at next edge, clear every valid bit and force state to IDLE. It overrides a same-cycle fill (the fill is dropped). ihit remains combinational during the inval cycle.
- Only one frame is written per fill. No write path from the datapath; the icache is read-only.

## Timing
- Reset values: state IDLE, ihit 0, imemload 0, iREN 0, iaddr 0. Asynchronous assertion mid-FETCH drops iREN immediately.
- Hit latency: 0 cycles (combinational from imemaddr).
- Miss latency, N = cycles iwait stays high after iREN rises:
  - cycle 0: miss detected in IDLE.
  - cycle 1..1+N: FETCH with iREN=1; fill at end of cycle 1+N.
  - cycle 2+N: ihit=1.
  - Total 2+N cycles of ihit=0 before the hit.
- ihit is never asserted in FETCH, including the fill cycle.
- Conflict miss (same index, different tag) overwrites the frame; the next access to the old tag misses again.
- imemREN low in IDLE: no transition, ihit 0, iREN 0.

## Test plan
- Reset, then imemREN=1, imemaddr=0x0000_0040, memory N=2, iload=0x2001_0005 → iREN high for cycles 1-3, iaddr=0x40; ihit=1 with imemload=0x2001_0005 at cycle 4; re-read gives 0-cycle hit.
- Fill 0x40, then read 0x80 (same index for SETS=16, different tag), then 0x40 again → three misses, each with a fill; valid data returned each time.
- Mid-FETCH (iwait high), change imemaddr from 0x100 to 0x200, then drop iwait with iload=0xDEAD_BEEF → frame for 0x200 filled; 0x100 still misses.
- FETCH with iwait high, drop imemREN → iREN low same cycle, FSM IDLE, no frame written.
- Fill 0x10, then pulse inval in the same cycle that a fill of 0x20 completes → both 0x10 and 0x20 miss afterwards.
- Assert nRST low mid-FETCH → iREN, ihit, iaddr 0 immediately; after release, the previously filled 0x40 misses.
